fifo_stream_ctrl: RTL
=====================

Name: fifo_stream_ctrl

Overview:
Sequencing controller for the parallel-write/parallel-read FIFO datapath (SIZE-bit words, PAR_WRITE in, PAR_READ out).
- Write side: packs a serial valid/ready word stream into PAR_WRITE-wide FIFO writes.
- Read side: unpacks PAR_READ-wide FIFO reads into a serial valid/ready stream.
- Also sequences the FIFO's synchronous clear.
- Sits between the producer/consumer streams and the FIFO instance.

Parameters:
- SIZE, 16, word width in bits
- PAR_WRITE, 2, words per FIFO write (>=1)
- PAR_READ, 4, words per FIFO read (>=1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- clear_req  in  1  request to flush controller and FIFO
- s_valid  in  1  upstream word valid
- s_ready  out  1  upstream word accepted when s_valid&&s_ready
- s_data  in  SIZE  upstream word
- m_valid  out  1  downstream word valid
- m_ready  in  1  downstream accepts when m_valid&&m_ready
- m_data  out  SIZE  downstream word
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_wen  out  1  FIFO write strobe
- fifo_din  out  SIZE*PAR_WRITE  FIFO write data, lane k = bits [SIZE*(k+1)-1:SIZE*k]
- fifo_ren  out  1  FIFO read strobe
- fifo_dout  in  SIZE*PAR_READ  FIFO head data; valid combinationally whenever fifo_empty=0 (show-ahead)
- fifo_clear  out  1  FIFO synchronous clear
- busy  out  1  controller holds data or is clearing

Behaviour:
- FSM states: RUN, CLR, WAIT.
  - Reset state is RUN.
  - RUN -> CLR when clear_req=1.
  - CLR -> WAIT unconditionally.
  - WAIT -> RUN unconditionally.
- Gating: run_ok = (state==RUN) && !clear_req. s_ready, m_valid, fifo_wen and fifo_ren are all ANDed with run_ok, so clear_req wins over same-cycle handshakes.
- Reset (rstn low, asynchronous): state=RUN; wcnt=0, rlanes=0, pack and hold registers cleared. Outputs during reset: s_ready=1, m_valid=0, m_data=0, fifo_wen=0, fifo_ren=0, fifo_clear=0, busy=0.
- Pack path:
  - wcnt counts 0..PAR_WRITE.
  - s_ready = run_ok && wcnt<PAR_WRITE.
  - On accept, s_data is written to pack lane wcnt and wcnt increments. Lane 0 is the first word.
- Write:
  - fifo_wen = run_ok && wcnt==PAR_WRITE && !fifo_full; fifo_din = pack register.
  - On fifo_wen, wcnt returns to 0 at the next edge.
  - No accept occurs in the write cycle, so sustained input throughput is PAR_WRITE words per PAR_WRITE+1 cycles.
  - While fifo_full=1 and wcnt==PAR_WRITE: stall, pack register held, s_ready=0.
- Unpack path:
  - rlanes counts 0..PAR_READ.
  - fifo_ren = run_ok && rlanes==0 && !fifo_empty. In the same edge, fifo_dout is captured into the hold register and rlanes=PAR_READ.
  - m_valid = run_ok && rlanes!=0.
  - m_data = hold lane (PAR_READ-rlanes), i.e. lane 0 first. m_data=0 when rlanes==0.
  - On m_valid&&m_ready, rlanes decrements.
  - m_data is stable while m_valid && !m_ready.
  - One bubble cycle (the ren cycle) occurs between consecutive read groups.
- Clear sequence:
  - CLR lasts one cycle with fifo_clear=1 (Moore output).
  - On entry to CLR, wcnt, rlanes, pack and hold are zeroed; partial words are discarded.
  - WAIT lasts one cycle to let FIFO flags settle; all strobes are 0.
  - Given clear_req sampled in cycle N, s_ready=0 during N, N+1, N+2 and RUN resumes at N+3.
  - clear_req held high re-enters CLR from RUN each time.
- busy = state!=RUN || wcnt!=0 || rlanes!=0.
- Counter widths: wcnt and rlanes are $clog2(PAR+1) bits; they never wrap.

Optional Feature:
- Macro: FIFO_STREAM_STATS_EN.
- Defined: adds two outputs, wr_words [31:0] and rd_words [31:0].
  - wr_words += PAR_WRITE on each fifo_wen.
  - rd_words += 1 on each m_valid&&m_ready.
  - Both reset to 0 on rstn and on CLR entry.
  - Both wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rstn=0 mid-transfer (wcnt=1, rlanes=3) -> m_valid=0, fifo_wen=0, fifo_ren=0 immediately without a clock edge; after release, s_ready=1 and busy=0.
- Pack: s_data 0x1111 then 0x2222 with fifo_full=0 -> one-cycle fifo_wen with fifo_din=0x2222_1111; s_ready low in that cycle, high the next.
- Full stall: wcnt=2 with fifo_full=1 for 5 cycles -> fifo_wen=0, s_ready=0, fifo_din held; fifo_full drops -> fifo_wen=1 in that same cycle.
- Unpack: fifo_empty=0, fifo_dout=0x4444_3333_2222_1111, m_ready=1 -> fifo_ren for one cycle, then m_data 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles; with m_ready toggling 1/0, each word is held until accepted.
- Clear mid-op: wcnt=1, rlanes=2, clear_req pulsed at cycle N -> fifo_clear=1 only at N+1; m_valid=0 and s_ready=0 for N..N+2; at N+3, wcnt=0, rlanes=0, busy=0, s_ready=1.
- Stats (macro defined): 3 writes and 12 read beats -> wr_words=6, rd_words=12; after clear_req, both read 0.

Source files
------------

// File: rtl/fifo_stream_ctrl.sv
// Stream-to-FIFO sequencing controller: packs serial words into wide FIFO writes,
// unpacks wide FIFO reads into a serial stream, and sequences the FIFO clear.
// Optional word counters are enabled by defining FIFO_STREAM_STATS_EN.
module fifo_stream_ctrl #(
    parameter int SIZE      = 16,
    parameter int PAR_WRITE = 2,
    parameter int PAR_READ  = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear_req,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SIZE-1:0]           s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [SIZE-1:0]           m_data,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    output logic                      fifo_wen,
    output logic [SIZE*PAR_WRITE-1:0] fifo_din,
    output logic                      fifo_ren,
    input  logic [SIZE*PAR_READ-1:0]  fifo_dout,
    output logic                      fifo_clear,
`ifdef FIFO_STREAM_STATS_EN
    output logic                      busy,
    output logic [31:0]               wr_words,
    output logic [31:0]               rd_words
`else
    output logic                      busy
`endif
);

    localparam int WCW = $clog2(PAR_WRITE + 1);
    localparam int RCW = $clog2(PAR_READ + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_CLR  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [WCW-1:0]                     r_wcnt;
    logic [RCW-1:0]                     r_rlanes;
    logic [PAR_WRITE-1:0][SIZE-1:0]     r_pack;
    logic [PAR_READ-1:0][SIZE-1:0]      r_hold;
    logic                               w_run_ok;
    logic                               w_clr_entry;
    logic [RCW-1:0]                     w_lane_idx;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLR;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_CLR:  w_state_nxt = ST_WAIT;
            ST_WAIT: w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // clear_req takes priority over any handshake in the same cycle
    assign w_run_ok    = (r_state == ST_RUN) && !clear_req;
    assign w_clr_entry = (r_state == ST_RUN) && clear_req;

    assign s_ready    = w_run_ok && (r_wcnt < WCW'(PAR_WRITE));
    assign fifo_wen   = w_run_ok && (r_wcnt == WCW'(PAR_WRITE)) && !fifo_full;
    assign fifo_din   = r_pack;
    assign fifo_ren   = w_run_ok && rstn && (r_rlanes == {RCW{1'b0}}) && !fifo_empty;
    assign m_valid    = w_run_ok && (r_rlanes != {RCW{1'b0}});
    assign fifo_clear = (r_state == ST_CLR);
    assign busy       = (r_state != ST_RUN) || (r_wcnt != {WCW{1'b0}}) ||
                        (r_rlanes != {RCW{1'b0}});
    assign w_lane_idx = RCW'(PAR_READ) - r_rlanes;

    // Output lane select: lane 0 is presented first after a read
    always_comb begin
        m_data = {SIZE{1'b0}};
        for (int k = 0; k < PAR_READ; k++) begin
            if ((r_rlanes != {RCW{1'b0}}) && (w_lane_idx == RCW'(k))) begin
                m_data = r_hold[k];
            end else begin
                m_data = m_data;
            end
        end
    end

    // Pack path: collect words, release counter when the group is written
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wcnt <= {WCW{1'b0}};
            r_pack <= '0;
        end else if (w_clr_entry) begin
            r_wcnt <= {WCW{1'b0}};
            r_pack <= '0;
        end else if (s_valid && s_ready) begin
            for (int k = 0; k < PAR_WRITE; k++) begin
                if (r_wcnt == WCW'(k)) begin
                    r_pack[k] <= s_data;
                end
            end
            r_wcnt <= r_wcnt + WCW'(1);
        end else if (fifo_wen) begin
            r_wcnt <= {WCW{1'b0}};
        end
    end

    // Unpack path: capture a read group, count lanes down as they are accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rlanes <= {RCW{1'b0}};
            r_hold   <= '0;
        end else if (w_clr_entry) begin
            r_rlanes <= {RCW{1'b0}};
            r_hold   <= '0;
        end else if (fifo_ren) begin
            r_hold   <= fifo_dout;
            r_rlanes <= RCW'(PAR_READ);
        end else if (m_valid && m_ready) begin
            r_rlanes <= r_rlanes - RCW'(1);
        end
    end

`ifdef FIFO_STREAM_STATS_EN
    // Word counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_words <= 32'd0;
            rd_words <= 32'd0;
        end else if (w_clr_entry) begin
            wr_words <= 32'd0;
            rd_words <= 32'd0;
        end else begin
            if (fifo_wen) begin
                wr_words <= wr_words + 32'(PAR_WRITE);
            end
            if (m_valid && m_ready) begin
                rd_words <= rd_words + 32'd1;
            end
        end
    end
`endif

endmodule
